// File: rtl/lbp_hist_pkg.sv
// Shared constants, FSM state encoding and the image-border test
// for the LBP histogram block.
package lbp_hist_pkg;

  localparam int NBINS  = 256;
  localparam int CNT_W  = 14;
  localparam int IMG_W  = 128;
  localparam int ADDR_W = 14;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2,
    CLEAR = 2'd3
  } state_e;

  // Border pixels have no full 3x3 neighbourhood, so their codes are meaningless
  function automatic logic on_border(input logic [ADDR_W-1:0] addr);
    logic [6:0] x;
    logic [6:0] y;
    x = addr[6:0];
    y = addr[13:7];
    return (x == 7'd0) || (x == 7'(IMG_W - 1)) ||
           (y == 7'd0) || (y == 7'(IMG_W - 1));
  endfunction

endpackage

// File: rtl/lbp_hist_if.sv
// LBP result input, control strobes and histogram drain handshake.
interface lbp_hist_if
  import lbp_hist_pkg::*;
#(
  parameter int CW = lbp_hist_pkg::CNT_W
) ();

  logic              lbp_valid;
  logic [ADDR_W-1:0] lbp_addr;
  logic [7:0]        lbp_data;
  logic              finish;
  logic              start;
  logic              hist_valid;
  logic              hist_ready;
  logic [7:0]        hist_bin;
  logic [CW-1:0]     hist_count;
  logic              hist_done;
  logic              overrun;

  modport master (
    output lbp_valid, lbp_addr, lbp_data, finish, start, hist_ready,
    input  hist_valid, hist_bin, hist_count, hist_done, overrun
  );

  modport slave (
    input  lbp_valid, lbp_addr, lbp_data, finish, start, hist_ready,
    output hist_valid, hist_bin, hist_count, hist_done, overrun
  );

endinterface

// File: rtl/lbp_hist_hist_bank.sv
// NBINS x CNT_W saturating counter array: one increment port,
// one clear port and one combinational read port.
module hist_bank #(
  parameter int NBINS = 256,
  parameter int CNT_W = 14,
  parameter int IDX_W = $clog2(NBINS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_en,
  input  logic [IDX_W-1:0] inc_idx,
  input  logic             clr_en,
  input  logic [IDX_W-1:0] clr_idx,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [CNT_W-1:0] rd_data
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] bins_q [NBINS];
  logic [CNT_W-1:0] bins_d [NBINS];

  // Next bin contents: clear has priority, increments stick at full scale
  always_comb begin
    bins_d = bins_q;
    if (clr_en) begin
      bins_d[clr_idx] = '0;
    end else if (inc_en && (bins_q[inc_idx] != CNT_MAX)) begin
      bins_d[inc_idx] = bins_q[inc_idx] + CNT_W'(1);
    end else begin
      bins_d[inc_idx] = bins_q[inc_idx];
    end
  end

  // Counter storage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NBINS; i++) begin
        bins_q[i] <= '0;
      end
    end else begin
      bins_q <= bins_d;
    end
  end

  assign rd_data = bins_q[rd_idx];

endmodule

// File: rtl/lbp_hist.sv
// LBP code histogram: accumulate interior-pixel codes, drain bins over a
// valid/ready handshake, then clear the bank on start for the next frame.
module lbp_hist
  import lbp_hist_pkg::*;
#(
  parameter int NBINS = lbp_hist_pkg::NBINS,
  parameter int CNT_W = lbp_hist_pkg::CNT_W
) (
  input  logic        clk,
  input  logic        reset,
  lbp_hist_if.slave   bus
);

  localparam int               IDX_W    = $clog2(NBINS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBINS - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             overrun_q, overrun_d;

  logic             inc_en_s;
  logic             clr_en_s;
  logic [CNT_W-1:0] rd_data_s;
  logic             hist_valid_s;
  logic             hist_done_s;
  logic [7:0]       hist_bin_s;
  logic [CNT_W-1:0] hist_count_s;

  hist_bank #(
    .NBINS (NBINS),
    .CNT_W (CNT_W),
    .IDX_W (IDX_W)
  ) u_bank (
    .clk     (clk),
    .reset   (reset),
    .inc_en  (inc_en_s),
    .inc_idx (IDX_W'(bus.lbp_data)),
    .clr_en  (clr_en_s),
    .clr_idx (idx_q),
    .rd_idx  (idx_q),
    .rd_data (rd_data_s)
  );

  // Next state, shared drain/clear index and overrun; outputs are zero off DRAIN
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    overrun_d    = overrun_q;
    inc_en_s     = 1'b0;
    clr_en_s     = 1'b0;
    hist_valid_s = 1'b0;
    hist_done_s  = 1'b0;
    hist_bin_s   = 8'd0;
    hist_count_s = '0;
    case (state_q)
      ACCUM: begin
        inc_en_s = bus.lbp_valid && !on_border(bus.lbp_addr);
        if (bus.finish) begin
          state_d = DRAIN;
          idx_d   = '0;
        end else begin
          state_d = ACCUM;
        end
      end
      DRAIN: begin
        hist_valid_s = 1'b1;
        hist_bin_s   = 8'(idx_q);
        hist_count_s = rd_data_s;
        overrun_d    = overrun_q | bus.lbp_valid;
        if (bus.hist_ready && (idx_q == LAST_IDX)) begin
          state_d = DONE;
          idx_d   = '0;
        end else if (bus.hist_ready) begin
          idx_d = idx_q + IDX_W'(1);
        end else begin
          idx_d = idx_q;
        end
      end
      DONE: begin
        hist_done_s = 1'b1;
        // Entering CLEAR wipes the flag even if a stray valid arrives alongside start
        if (bus.start) begin
          state_d   = CLEAR;
          idx_d     = '0;
          overrun_d = 1'b0;
        end else begin
          overrun_d = overrun_q | bus.lbp_valid;
        end
      end
      CLEAR: begin
        clr_en_s  = 1'b1;
        overrun_d = overrun_q | bus.lbp_valid;
        if (idx_q == LAST_IDX) begin
          state_d = ACCUM;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = ACCUM;
        idx_d   = '0;
      end
    endcase
  end

  // Control state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ACCUM;
      idx_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.hist_valid = hist_valid_s;
  assign bus.hist_done  = hist_done_s;
  assign bus.hist_bin   = hist_bin_s;
  assign bus.hist_count = hist_count_s;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_lbp_hist.sv
// Randomized self-checking bench for lbp_hist against a frame-level
// histogram model, with literal spot checks on the directed scenarios.
module tb_lbp_hist;
  import lbp_hist_pkg::*;

  localparam int MAXC    = (1 << CNT_W) - 1;
  localparam int P_ACC   = 0;
  localparam int P_DRAIN = 1;
  localparam int P_DONE  = 2;
  localparam int P_CLEAR = 3;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  lbp_hist_if bus ();

  lbp_hist dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model: per-bin counts, current phase, drain position, overrun
  int m_cnt [NBINS];
  int m_phase      = P_ACC;
  int m_idx        = 0;
  int m_clear_left = 0;
  bit m_ovr        = 1'b0;

  function automatic bit interior(input logic [13:0] a);
    int x;
    int y;
    x = int'(a) % IMG_W;
    y = int'(a) / IMG_W;
    return (x > 0) && (x < IMG_W - 1) && (y > 0) && (y < IMG_W - 1);
  endfunction

  function automatic logic [13:0] iaddr(input int n);
    return {7'(1 + (n / 126) % 126), 7'(1 + n % 126)};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase      <= P_ACC;
      m_idx        <= 0;
      m_ovr        <= 1'b0;
      m_clear_left <= 0;
      for (int i = 0; i < NBINS; i++) m_cnt[i] <= 0;
    end else begin
      case (m_phase)
        P_ACC: begin
          if (bus.lbp_valid && interior(bus.lbp_addr) && m_cnt[bus.lbp_data] < MAXC)
            m_cnt[bus.lbp_data] <= m_cnt[bus.lbp_data] + 1;
          if (bus.finish) begin
            m_phase <= P_DRAIN;
            m_idx   <= 0;
          end
        end
        P_DRAIN: begin
          if (bus.lbp_valid) m_ovr <= 1'b1;
          if (bus.hist_ready) begin
            if (m_idx == NBINS - 1) m_phase <= P_DONE;
            else m_idx <= m_idx + 1;
          end
        end
        P_DONE: begin
          if (bus.lbp_valid) m_ovr <= 1'b1;
          if (bus.start) begin
            m_phase      <= P_CLEAR;
            m_clear_left <= NBINS;
            m_ovr        <= 1'b0;
          end
        end
        default: begin
          if (bus.lbp_valid) m_ovr <= 1'b1;
          if (m_clear_left == 1) begin
            m_phase <= P_ACC;
            for (int i = 0; i < NBINS; i++) m_cnt[i] <= 0;
          end else begin
            m_clear_left <= m_clear_left - 1;
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    chk("hist_valid", bus.hist_valid, int'(m_phase == P_DRAIN));
    chk("hist_bin", bus.hist_bin, (m_phase == P_DRAIN) ? m_idx : 0);
    chk("hist_count", bus.hist_count, (m_phase == P_DRAIN) ? m_cnt[m_idx] : 0);
    chk("hist_done", bus.hist_done, int'(m_phase == P_DONE));
    chk("overrun", bus.overrun, int'(m_ovr));
  end

  task automatic cyc(input logic v, input logic [13:0] a, input logic [7:0] d,
                     input logic f, input logic s, input logic r);
    @(negedge clk);
    #1;
    bus.lbp_valid  = v;
    bus.lbp_addr   = a;
    bus.lbp_data   = d;
    bus.finish     = f;
    bus.start      = s;
    bus.hist_ready = r;
  endtask

  task automatic idle(input logic r);
    cyc(1'b0, 14'd0, 8'd0, 1'b0, 1'b0, r);
  endtask

  task automatic run_drain(input int budget, input int pin_bin, input int pin_cnt,
                           input bit noisy, output int acc, output int sum);
    acc = 0;
    sum = 0;
    for (int k = 0; k < budget; k++) begin
      logic r;
      logic v;
      logic s;
      logic f;
      if (bus.hist_done) break;
      r = noisy ? ($urandom_range(0, 9) < 6) : 1'b1;
      v = noisy && ($urandom_range(0, 9) == 0);
      s = noisy && ($urandom_range(0, 19) == 0);
      f = noisy && ($urandom_range(0, 19) == 0);
      if (pin_bin >= 0 && bus.hist_valid && bus.hist_bin == 8'(pin_bin))
        chk("pinned_bin_count", bus.hist_count, pin_cnt);
      if (bus.hist_valid && r) begin
        acc++;
        sum += int'(bus.hist_count);
      end
      cyc(v, 14'($urandom), 8'($urandom), f, s, r);
    end
    chk("drain_reaches_done", bus.hist_done, 1);
  endtask

  task automatic restart(input bit noisy);
    cyc(1'b0, 14'd0, 8'd0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < NBINS; k++) begin
      if (noisy && k < NBINS - 6)
        cyc($urandom_range(0, 3) == 0, 14'($urandom), 8'($urandom),
            $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, 1'($urandom));
      else
        idle(1'b0);
    end
  endtask

  task automatic random_frame();
    int n;
    int acc;
    int sum;
    logic [13:0] a;
    n = $urandom_range(40, 300);
    for (int i = 0; i < n; i++) begin
      a = 14'($urandom);
      case ($urandom_range(0, 4))
        0: a[6:0]  = ($urandom_range(0, 1) == 0) ? 7'd0 : 7'd127;
        1: a[13:7] = ($urandom_range(0, 1) == 0) ? 7'd0 : 7'd127;
        default: a = iaddr($urandom_range(0, 15875));
      endcase
      cyc($urandom_range(0, 9) < 7, a,
          ($urandom_range(0, 1) == 0) ? 8'($urandom) : 8'(85 * $urandom_range(0, 3)),
          i == n - 1, $urandom_range(0, 19) == 0, 1'($urandom));
    end
    run_drain(4000, -1, 0, 1'b1, acc, sum);
    repeat ($urandom_range(1, 5))
      cyc($urandom_range(0, 2) == 0, 14'($urandom), 8'($urandom), 1'($urandom), 1'b0, 1'($urandom));
    restart(1'b1);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog expired got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int sum;
    int held;
    bus.lbp_valid  = 1'b0;
    bus.lbp_addr   = 14'd0;
    bus.lbp_data   = 8'd0;
    bus.finish     = 1'b0;
    bus.start      = 1'b0;
    bus.hist_ready = 1'b0;
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_hist_valid", bus.hist_valid, 0);
    chk("rst_hist_done", bus.hist_done, 0);
    chk("rst_overrun", bus.overrun, 0);
    chk("rst_hist_bin", bus.hist_bin, 0);
    chk("rst_hist_count", bus.hist_count, 0);
    reset = 1'b0;

    // Repeated 0xA5 with one border sample, then a 1,0,0,1 ready pattern
    cyc(1'b1, {7'd10, 7'd10}, 8'hA5, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, {7'd10, 7'd11}, 8'hA5, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, {7'd0, 7'd5}, 8'hA5, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, {7'd20, 7'd30}, 8'hA5, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 14'd0, 8'd0, 1'b1, 1'b0, 1'b0);
    idle(1'b0);
    chk("drain_entry_valid", bus.hist_valid, 1);
    chk("drain_entry_bin", bus.hist_bin, 0);
    idle(1'b1);
    idle(1'b0);
    chk("bp_bin_after_accept", bus.hist_bin, 1);
    held = int'(bus.hist_count);
    idle(1'b0);
    chk("bp_bin_held1", bus.hist_bin, 1);
    chk("bp_count_held1", bus.hist_count, held);
    idle(1'b1);
    chk("bp_bin_held2", bus.hist_bin, 1);
    idle(1'b0);
    chk("bp_bin_next", bus.hist_bin, 2);
    run_drain(600, 'hA5, 3, 1'b0, acc, sum);
    chk("a5_sum", sum, 3);
    restart(1'b0);

    // finish coinciding with the last valid
    cyc(1'b1, {7'd5, 7'd5}, 8'h3C, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, {7'd6, 7'd6}, 8'h3C, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    chk("finish_drain_next", bus.hist_valid, 1);
    run_drain(600, 'h3C, 2, 1'b0, acc, sum);

    // Valid during DONE sets overrun; start clears it and the bank
    cyc(1'b1, {7'd9, 7'd9}, 8'h11, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    chk("overrun_set", bus.overrun, 1);
    chk("done_held", bus.hist_done, 1);
    restart(1'b0);
    idle(1'b0);
    chk("overrun_cleared", bus.overrun, 0);
    chk("done_dropped", bus.hist_done, 0);
    cyc(1'b0, 14'd0, 8'd0, 1'b1, 1'b0, 1'b0);
    run_drain(600, -1, 0, 1'b0, acc, sum);
    chk("cleared_sum", sum, 0);
    chk("cleared_accepts", acc, NBINS);
    restart(1'b0);

    // Full frame of interior pixels, all code 0x00
    for (int y = 1; y <= 126; y++)
      for (int x = 1; x <= 126; x++)
        cyc(1'b1, {7'(y), 7'(x)}, 8'h00, (y == 126) && (x == 126), 1'b0, 1'b0);
    run_drain(600, 0, 15876, 1'b0, acc, sum);
    chk("frame_accepts", acc, 256);
    chk("frame_sum", sum, 15876);
    restart(1'b1);

    for (int f = 0; f < 6; f++) random_frame();

    // Saturation of a single bin
    for (int n = 0; n < 16390; n++)
      cyc(1'b1, iaddr(n), 8'h77, n == 16389, 1'b0, 1'b0);
    run_drain(600, 'h77, MAXC, 1'b0, acc, sum);
    chk("sat_sum", sum, MAXC);
    restart(1'b0);

    // Reset while draining bin 100
    for (int k = 0; k < 5; k++)
      cyc(1'b1, iaddr(k), 8'hC8, k == 4, 1'b0, 1'b0);
    for (int k = 0; k < 400; k++) begin
      if (bus.hist_valid && bus.hist_bin == 8'd100) break;
      idle(1'b1);
    end
    chk("reached_bin100", bus.hist_bin, 100);
    reset = 1'b1;
    #1;
    chk("abort_hist_valid", bus.hist_valid, 0);
    chk("abort_hist_bin", bus.hist_bin, 0);
    chk("abort_hist_count", bus.hist_count, 0);
    idle(1'b0);
    idle(1'b0);
    reset = 1'b0;
    cyc(1'b0, 14'd0, 8'd0, 1'b1, 1'b0, 1'b0);
    run_drain(600, 'hC8, 0, 1'b0, acc, sum);
    chk("post_reset_sum", sum, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
